vmult_seq: RTL
==============

# vmult_seq

Vector sequencer around the pipelined half-precision multiplier (`VMULTp`). It latches two packed vectors of `LANES` half-precision operands on `Start` and issues one element pair per cycle to the multiplier. It collects each product one cycle later, when the multiplier's register stage has advanced, and assembles the result vector and per-lane overflow flags. It then pulses `Done`. The block is both the multiplier's operand source and its product sink in the vector datapath.

## Interface
- `LANES`, 16, number of 16-bit elements per vector (2..32)
- `Clk2`  in  1  clock; same clock that drives the multiplier pipeline register
- `Rst`  in  1  synchronous, active-high reset
- `Start`  in  1  begin operation; sampled only in IDLE
- `VecA`  in  16*LANES  operand vector A; lane i = bits [16i+15:16i]
- `VecB`  in  16*LANES  operand vector B, same packing
- `Busy`  out  1  high in ISSUE and DRAIN
- `Done`  out  1  one-cycle pulse, result valid
- `VecOut`  out  16*LANES  product vector, same packing; held until next accepted `Start`
- `OvfFlags`  out  LANES  per-lane overflow, from multiplier `Overflow`
- `OvfAny`  out  1  OR of `OvfFlags`
- `MultA`, `MultB`  out  16  registered operands to multiplier `A`/`B`
- `MultProd`  in  16  multiplier `product`
- `MultOvf`  in  1  multiplier `Overflow`

## Operation
- The states are IDLE, ISSUE, DRAIN, and DONE.
- **IDLE:** `Start`=1 at an edge triggers the following at that edge.
  - Latch `VecA`/`VecB` into internal operand registers.
  - Clear `OvfFlags`.
  - Set issue index to 0, go to ISSUE.
  - `VecOut` is not cleared.
- **ISSUE:** each cycle drives `MultA`/`MultB` = latched lane `idx` and sets capture-valid for the next cycle.
  - `idx` increments at each edge.
  - At the edge where `idx`=`LANES`-1, go to DRAIN.
- **Capture:** when capture-valid is set, the edge writes the capture lane (= previous issue index).
  - `VecOut` lane ← `MultProd`.
  - `OvfFlags` bit ← `MultOvf`.
- **DRAIN:** no issue; `MultA`/`MultB` = 0; captures lane `LANES`-1; next state is DONE.
- **DONE:** `Done`=1 for exactly one cycle, then IDLE. `Start` is ignored in DONE.
- `Start` in ISSUE/DRAIN is ignored; operands in flight are not disturbed.
- `MultA`/`MultB` are 0 in IDLE, DRAIN and DONE.
- The index counter is ceil(log2(`LANES`)) bits and does not wrap during an operation.

## Timing
- Call the edge accepting `Start` E0 and the cycle after edge Ek cycle k+1.
- Lane i is issued in cycle i+1. It appears on `MultProd` in cycle i+2 and is captured at edge E(i+2).
- `Busy` is high in cycles 1..`LANES`+1.
- `Done` is high in cycle `LANES`+2. This is fixed latency, independent of data.
- The earliest next accepted `Start` is at the edge ending cycle `LANES`+3 (first IDLE cycle).
- **Reset** (any state, mid-operation included) returns to IDLE at the next edge and abandons in-flight lanes.
  - `Busy`=0, `Done`=0.
  - `VecOut`=0, `OvfFlags`=0, `OvfAny`=0.
  - `MultA`=`MultB`=0.
  - Operand registers = 0, index = 0, capture-valid = 0.
- `Rst` and `Start` asserted together: reset wins.
- All outputs are registered except `OvfAny`, which is combinational OR of registered flags.

## Configuration
- `VMULT_SEQ_SAT_EN` defined: a lane captured with `MultOvf`=1 stores the signed max finite value {`MultProd`[15], 15'h7BFF}, i.e. 0x7BFF or 0xFBFF. The overflow flag is still set.
- Not defined: the lane stores `MultProd` unchanged (multiplier's overflow encoding, exponent all ones and mantissa 0, i.e. 0x7C00/0xFC00).

## Test plan
- **Basic, `LANES`=16.** All lanes A=B=0x3C00, reference multiplier attached, pulse `Start` → `Busy` high cycles 1..17; `Done` pulse in cycle 18 only; every `VecOut` lane 0x3C00; `OvfFlags`=0.
- **Lane ordering and sign.** Lane i of A = 0xBC00 for odd i, 0x3C00 for even i; B all 0x3C00 → odd lanes 0xBC00, even lanes 0x3C00; proves the capture index trails the issue index by one.
- **Overflow.** Lane 5 A=0x7AAA, B=0x7ADE, others 1.0×1.0:
  - `OvfFlags`=16'h0020, `OvfAny`=1.
  - Lane 5 = 0x7C00 without `VMULT_SEQ_SAT_EN`, 0x7BFF with it.
  - Other lanes 0x3C00.
- **Start while busy.** Second `Start` with different vectors in cycle 8 → ignored; `Done` still in cycle 18 with the first operation's results; no second `Done`.
- **Reset mid-operation.** Assert `Rst` in cycle 10 for one cycle → next cycle all outputs 0, state IDLE, no `Done`. A new `Start` afterwards completes normally with correct results.
- **Back-to-back.** `Start` held high continuously → operations accepted at E0 and at the first IDLE edge after `Done` (cycle 19 edge). Second `Done` follows 18 cycles after the second acceptance.

Source files
------------

// File: rtl/vmult_seq_if.sv
// rtl/vmult_seq_if.sv - operand/product bus between vmult_seq and the VMULTp multiplier
interface vmult_seq_if;
  logic [15:0] MultA;
  logic [15:0] MultB;
  logic [15:0] MultProd;
  logic        MultOvf;

  modport master (output MultA, output MultB, input MultProd, input MultOvf);
  modport slave  (input MultA, input MultB, output MultProd, output MultOvf);
endinterface

// File: rtl/vmult_seq.sv
// rtl/vmult_seq.sv - vector sequencer feeding VMULTp one lane per cycle (VMULT_SEQ_SAT_EN: saturate overflowed lanes)
module vmult_seq #(
  parameter int LANES = 16
) (
  input  logic                 Clk2,
  input  logic                 Rst,
  input  logic                 Start,
  input  logic [16*LANES-1:0]  VecA,
  input  logic [16*LANES-1:0]  VecB,
  output logic                 Busy,
  output logic                 Done,
  output logic [16*LANES-1:0]  VecOut,
  output logic [LANES-1:0]     OvfFlags,
  output logic                 OvfAny,
  vmult_seq_if.master          mult
);

  localparam int IW = $clog2(LANES);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] idx, idx_inc, cap_idx;
  logic          cap_valid;
  logic          last_issue;
  logic [15:0]   op_a [LANES];
  logic [15:0]   op_b [LANES];
  logic [15:0]   res  [LANES];
  logic [15:0]   mult_a_nxt, mult_b_nxt;
  logic [15:0]   cap_word;

  assign idx_inc    = idx + 1'b1;
  assign last_issue = (idx == IW'(LANES - 1));
  assign OvfAny     = |OvfFlags;

`ifdef VMULT_SEQ_SAT_EN
  assign cap_word = mult.MultOvf ? {mult.MultProd[15], 15'h7BFF} : mult.MultProd;
`else
  assign cap_word = mult.MultProd;
`endif

  for (genvar g = 0; g < LANES; g++) begin : g_out
    assign VecOut[16*g +: 16] = res[g];
  end

  // Operands are registered one edge ahead, so lane i is on MultA/MultB during cycle i+1.
  always_comb begin
    state_nxt  = state;
    mult_a_nxt = '0;
    mult_b_nxt = '0;
    case (state)
      IDLE: begin
        if (Start) begin
          state_nxt  = ISSUE;
          mult_a_nxt = VecA[15:0];
          mult_b_nxt = VecB[15:0];
        end
      end
      ISSUE: begin
        if (last_issue) begin
          state_nxt = DRAIN;
        end else begin
          mult_a_nxt = op_a[idx_inc];
          mult_b_nxt = op_b[idx_inc];
        end
      end
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk2) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge Clk2) begin
    if (Rst) begin
      idx        <= '0;
      cap_idx    <= '0;
      cap_valid  <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      OvfFlags   <= '0;
      mult.MultA <= '0;
      mult.MultB <= '0;
      for (int i = 0; i < LANES; i++) begin
        op_a[i] <= '0;
        op_b[i] <= '0;
        res[i]  <= '0;
      end
    end else begin
      mult.MultA <= mult_a_nxt;
      mult.MultB <= mult_b_nxt;
      Busy       <= (state_nxt == ISSUE) || (state_nxt == DRAIN);
      Done       <= (state_nxt == DONE);
      // Product of the lane issued this cycle arrives next cycle.
      cap_valid  <= (state == ISSUE);
      cap_idx    <= idx;

      if (state == IDLE && Start) begin
        idx      <= '0;
        OvfFlags <= '0;
        for (int i = 0; i < LANES; i++) begin
          op_a[i] <= VecA[16*i +: 16];
          op_b[i] <= VecB[16*i +: 16];
        end
      end else if (state == ISSUE && !last_issue) begin
        idx <= idx_inc;
      end

      if (cap_valid) begin
        res[cap_idx]      <= cap_word;
        OvfFlags[cap_idx] <= mult.MultOvf;
      end
    end
  end

endmodule
